// File: rtl/sha512_pkg.sv
// Shared types for the SHA-512 block scheduler: line/digest types, block geometry and FSM states.
package sha512_pkg;

  localparam int SHA512_LINE_W      = 512;
  localparam int SHA512_BLOCK_LINES = 2;
  localparam int SHA512_BLOCK_W     = SHA512_LINE_W * SHA512_BLOCK_LINES;

  typedef logic [SHA512_LINE_W-1:0]  t_block;
  typedef logic [511:0]              t_digest;
  typedef logic [SHA512_BLOCK_W-1:0] t_core_block;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    ISSUE,
    WAIT_CORE,
    DIGEST
  } t_sched_state;

endpackage

// File: rtl/sha512_sched_perf.sv
// Saturating stall-cycle counter; cleared on message accept, holds at all-ones.
module sha512_sched_perf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             stall,
  output logic [CNT_W-1:0] stall_cyc
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cyc <= '0;
    end else if (clr) begin
      stall_cyc <= '0;
    end else if (stall && (stall_cyc != {CNT_W{1'b1}})) begin
      stall_cyc <= stall_cyc + 1'b1;
    end
  end

endmodule

// File: rtl/sha512_block_sched.sv
// Feeds one message block-by-block into the SHA-512 core; pop-to-start latency 1 cycle, digest held until digest_ready.
// Stall counter is built only when SHA512_SCHED_PERF_EN is defined; otherwise perf_stall_cyc reads 0.
module sha512_block_sched
  import sha512_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [CNT_W-1:0]                 cfg_num_blocks,
  input  logic                             cfg_valid,
  output logic                             cfg_ready,
  input  t_block [SHA512_BLOCK_LINES-1:0]  fifo_data,
  input  logic                             fifo_not_empty,
  output logic                             fifo_deq_en,
  output logic                             core_start,
  output logic                             core_init,
  output t_core_block                      core_block,
  input  logic                             core_done,
  input  t_digest                          core_digest,
  output t_digest                          digest_out,
  output logic                             digest_valid,
  input  logic                             digest_ready,
  output logic [CNT_W-1:0]                 blocks_done,
  output logic [CNT_W-1:0]                 perf_stall_cyc
);

  t_sched_state     state_q, state_d;
  logic [CNT_W-1:0] num_blocks_q;
  logic [CNT_W-1:0] blocks_nxt;
  logic             msg_accept;
  logic             block_done;
  logic             last_block;

  assign blocks_nxt = blocks_done + 1'b1;
  assign last_block = (blocks_nxt == num_blocks_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cfg_ready    = 1'b0;
    fifo_deq_en  = 1'b0;
    core_start   = 1'b0;
    core_init    = 1'b0;
    digest_valid = 1'b0;
    msg_accept   = 1'b0;
    block_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          msg_accept = 1'b1;
          // A zero-length message is accepted and dropped without touching the FIFO or core.
          if (cfg_num_blocks != '0) begin
            state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (fifo_not_empty) begin
          fifo_deq_en = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        core_start = 1'b1;
        core_init  = (blocks_done == '0);
        state_d    = WAIT_CORE;
      end
      WAIT_CORE: begin
        if (core_done) begin
          block_done = 1'b1;
          state_d    = last_block ? DIGEST : WAIT_DATA;
        end
      end
      DIGEST: begin
        digest_valid = 1'b1;
        if (digest_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      num_blocks_q <= '0;
      blocks_done  <= '0;
      core_block   <= '0;
      digest_out   <= '0;
    end else begin
      if (msg_accept) begin
        num_blocks_q <= cfg_num_blocks;
        blocks_done  <= '0;
      end
      if (fifo_deq_en) begin
        core_block <= {fifo_data[1], fifo_data[0]};
      end
      if (block_done) begin
        blocks_done <= blocks_nxt;
        if (last_block) begin
          digest_out <= core_digest;
        end
      end
    end
  end

`ifdef SHA512_SCHED_PERF_EN
  logic perf_stall;
  assign perf_stall = (state_q == WAIT_DATA) && !fifo_not_empty;

  sha512_sched_perf #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk       (clk),
    .reset     (reset),
    .clr       (msg_accept),
    .stall     (perf_stall),
    .stall_cyc (perf_stall_cyc)
  );
`else
  assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_sha512_block_sched.sv
// Directed bench for sha512_block_sched: single/multi-block messages, zero count, backpressure, reset, spurious inputs.
module tb_sha512_block_sched;
  import sha512_pkg::*;

`ifdef SHA512_SCHED_PERF_EN
  localparam logic [31:0] EXP_STALL = 32'd10;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
`endif

  logic                            clk = 1'b0;
  logic                            reset;
  logic [31:0]                     cfg_num_blocks;
  logic                            cfg_valid;
  logic                            cfg_ready;
  t_block [SHA512_BLOCK_LINES-1:0] fifo_data;
  logic                            fifo_not_empty;
  logic                            fifo_deq_en;
  logic                            core_start;
  logic                            core_init;
  t_core_block                     core_block;
  logic                            core_done;
  t_digest                         core_digest;
  t_digest                         digest_out;
  logic                            digest_valid;
  logic                            digest_ready;
  logic [31:0]                     blocks_done;
  logic [31:0]                     perf_stall_cyc;

  int checks = 0;
  int errors = 0;

  sha512_block_sched #(.CNT_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_num_blocks (cfg_num_blocks),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .fifo_data      (fifo_data),
    .fifo_not_empty (fifo_not_empty),
    .fifo_deq_en    (fifo_deq_en),
    .core_start     (core_start),
    .core_init      (core_init),
    .core_block     (core_block),
    .core_done      (core_done),
    .core_digest    (core_digest),
    .digest_out     (digest_out),
    .digest_valid   (digest_valid),
    .digest_ready   (digest_ready),
    .blocks_done    (blocks_done),
    .perf_stall_cyc (perf_stall_cyc)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0; cfg_valid = 1'b0; cfg_num_blocks = '0; fifo_data = '0;
    fifo_not_empty = 1'b0; core_done = 1'b0; core_digest = '0; digest_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
    checks++; if (fifo_deq_en !== 1'b0) begin errors++; $display("FAIL reset_deq got=%b exp=0", fifo_deq_en); end
    checks++; if (core_start !== 1'b0 || core_init !== 1'b0) begin errors++; $display("FAIL reset_start got=%b%b exp=00", core_start, core_init); end
    checks++; if (core_block !== '0) begin errors++; $display("FAIL reset_core_block got=%h exp=0", core_block); end
    checks++; if (digest_out !== '0 || digest_valid !== 1'b0) begin errors++; $display("FAIL reset_digest got=%b %h exp=0", digest_valid, digest_out); end
    checks++; if (blocks_done !== 32'd0 || perf_stall_cyc !== 32'd0) begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", blocks_done, perf_stall_cyc); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_block();
    t_block  a = {8{64'h1111_2222_3333_0001}};
    t_block  b = {8{64'hBBBB_CCCC_DDDD_0002}};
    t_digest d = {8{64'hDEAD_BEEF_0123_4567}};
    cfg_num_blocks = 32'd1; cfg_valid = 1'b1; #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL single_cfg_ready got=%b exp=1", cfg_ready); end
    @(negedge clk); cfg_valid = 1'b0;
    fifo_data[0] = a; fifo_data[1] = b; fifo_not_empty = 1'b1; #1;
    checks++; if (fifo_deq_en !== 1'b1) begin errors++; $display("FAIL single_deq got=%b exp=1", fifo_deq_en); end
    @(negedge clk); fifo_not_empty = 1'b0; #1;
    checks++; if (core_start !== 1'b1 || core_init !== 1'b1) begin errors++; $display("FAIL single_start got=%b%b exp=11", core_start, core_init); end
    checks++; if (core_block !== {b, a}) begin errors++; $display("FAIL single_block got=%h exp=%h", core_block, {b, a}); end
    checks++; if (fifo_deq_en !== 1'b0) begin errors++; $display("FAIL single_deq_once got=%b exp=0", fifo_deq_en); end
    @(negedge clk); #1;
    checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse got=%b exp=0", core_start); end
    core_done = 1'b1; core_digest = d;
    @(negedge clk); core_done = 1'b0; core_digest = '0; #1;
    checks++; if (digest_valid !== 1'b1 || digest_out !== d) begin errors++; $display("FAIL single_digest got=%b %h exp=1 %h", digest_valid, digest_out, d); end
    checks++; if (blocks_done !== 32'd1) begin errors++; $display("FAIL single_blocks_done got=%0d exp=1", blocks_done); end
    digest_ready = 1'b1;
    @(negedge clk); digest_ready = 1'b0; #1;
    checks++; if (cfg_ready !== 1'b1 || digest_valid !== 1'b0) begin errors++; $display("FAIL single_idle got=%b%b exp=10", cfg_ready, digest_valid); end
  endtask

  task automatic test_multi_block();
    t_block      l0, l1;
    t_digest     d;
    logic [31:0] w;
    int          stall;
    cfg_num_blocks = 32'd3; cfg_valid = 1'b1;
    @(negedge clk); cfg_valid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      w = 32'h5000_0000 + b;
      l0 = {16{w}}; l1 = {16{~w}}; d = {16{w ^ 32'h0F0F_0F0F}};
      stall = (b == 1) ? 10 : 0;
      fifo_not_empty = 1'b0;
      repeat (stall) @(negedge clk);
      fifo_data[0] = l0; fifo_data[1] = l1; fifo_not_empty = 1'b1; #1;
      checks++; if (fifo_deq_en !== 1'b1) begin errors++; $display("FAIL multi_deq blk=%0d got=%b exp=1", b, fifo_deq_en); end
      @(negedge clk); fifo_not_empty = 1'b0; #1;
      checks++; if (core_start !== 1'b1 || core_init !== (b == 0)) begin errors++; $display("FAIL multi_init blk=%0d got=%b%b exp=1%b", b, core_start, core_init, b == 0); end
      checks++; if (core_block !== {l1, l0}) begin errors++; $display("FAIL multi_block blk=%0d got=%h", b, core_block); end
      @(negedge clk);
      core_done = 1'b1; core_digest = d;
      @(negedge clk); core_done = 1'b0; #1;
      checks++; if (blocks_done !== 32'(b + 1)) begin errors++; $display("FAIL multi_blocks_done got=%0d exp=%0d", blocks_done, b + 1); end
      checks++; if (digest_valid !== (b == 2)) begin errors++; $display("FAIL multi_digest_valid blk=%0d got=%b exp=%b", b, digest_valid, b == 2); end
    end
    checks++; if (digest_out !== d) begin errors++; $display("FAIL multi_digest got=%h exp=%h", digest_out, d); end
    checks++; if (perf_stall_cyc !== EXP_STALL) begin errors++; $display("FAIL multi_perf got=%0d exp=%0d", perf_stall_cyc, EXP_STALL); end
    digest_ready = 1'b1;
    @(negedge clk); digest_ready = 1'b0; #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL multi_idle got=%b exp=1", cfg_ready); end
  endtask

  task automatic test_zero_count();
    int bad = 0;
    cfg_num_blocks = 32'd0; cfg_valid = 1'b1; fifo_not_empty = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); cfg_valid = 1'b0; #1;
      if (cfg_ready !== 1'b1 || fifo_deq_en !== 1'b0 || core_start !== 1'b0 || digest_valid !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL zero_count bad_cycles got=%0d exp=0", bad); end
    fifo_not_empty = 1'b0;
  endtask

  task automatic test_digest_backpressure();
    t_digest d = {8{64'hCAFE_F00D_0000_0004}};
    int bad = 0;
    cfg_num_blocks = 32'd1; cfg_valid = 1'b1;
    @(negedge clk); cfg_valid = 1'b0; fifo_data = '1; fifo_not_empty = 1'b1;
    @(negedge clk); fifo_not_empty = 1'b0;
    @(negedge clk);
    core_done = 1'b1; core_digest = d;
    @(negedge clk); core_done = 1'b0; core_digest = '0; fifo_not_empty = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (digest_valid !== 1'b1 || digest_out !== d || fifo_deq_en !== 1'b0 ||
          cfg_ready !== 1'b0 || core_start !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL backpressure_hold bad_cycles got=%0d exp=0", bad); end
    digest_ready = 1'b1;
    @(negedge clk); digest_ready = 1'b0; fifo_not_empty = 1'b0; #1;
    checks++; if (cfg_ready !== 1'b1 || digest_valid !== 1'b0) begin errors++; $display("FAIL backpressure_release got=%b%b exp=10", cfg_ready, digest_valid); end
    checks++; if (digest_out !== d) begin errors++; $display("FAIL backpressure_digest_keep got=%h exp=%h", digest_out, d); end
  endtask

  task automatic test_reset_mid_message();
    cfg_num_blocks = 32'd2; cfg_valid = 1'b1;
    @(negedge clk); cfg_valid = 1'b0; fifo_data = {2{{8{64'h7777_0000_0000_0005}}}}; fifo_not_empty = 1'b1;
    @(negedge clk); fifo_not_empty = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1; #1;
    checks++; if (cfg_ready !== 1'b1 || core_start !== 1'b0 || digest_valid !== 1'b0) begin errors++; $display("FAIL midreset_ctrl got=%b%b%b exp=100", cfg_ready, core_start, digest_valid); end
    checks++; if (core_block !== '0 || digest_out !== '0) begin errors++; $display("FAIL midreset_data got=%h", core_block); end
    core_done = 1'b1; core_digest = '1;
    @(negedge clk); core_done = 1'b0; core_digest = '0; #1;
    checks++; if (blocks_done !== 32'd0 || cfg_ready !== 1'b1 || digest_valid !== 1'b0) begin errors++; $display("FAIL midreset_done_ignored got=%0d %b%b exp=0 10", blocks_done, cfg_ready, digest_valid); end
  endtask

  task automatic test_spurious_inputs();
    t_digest d = {8{64'h0BAD_0000_1234_0006}};
    core_done = 1'b1;
    @(negedge clk); core_done = 1'b0; #1;
    checks++; if (blocks_done !== 32'd0 || cfg_ready !== 1'b1) begin errors++; $display("FAIL spur_idle_done got=%0d %b exp=0 1", blocks_done, cfg_ready); end
    cfg_num_blocks = 32'd2; cfg_valid = 1'b1;
    @(negedge clk); cfg_valid = 1'b0; core_done = 1'b1;
    @(negedge clk); core_done = 1'b0; #1;
    checks++; if (blocks_done !== 32'd0 || core_start !== 1'b0) begin errors++; $display("FAIL spur_waitdata_done got=%0d %b exp=0 0", blocks_done, core_start); end
    cfg_num_blocks = 32'd1; cfg_valid = 1'b1; #1;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL spur_cfg_ready got=%b exp=0", cfg_ready); end
    @(negedge clk); cfg_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      fifo_data = {2{{16{32'(b)}}}}; fifo_not_empty = 1'b1;
      @(negedge clk); fifo_not_empty = 1'b0;
      @(negedge clk); cfg_valid = 1'b1; cfg_num_blocks = 32'd1;
      @(negedge clk); cfg_valid = 1'b0; core_done = 1'b1; core_digest = d;
      @(negedge clk); core_done = 1'b0; #1;
      checks++; if (blocks_done !== 32'(b + 1) || digest_valid !== (b == 1)) begin errors++; $display("FAIL spur_progress blk=%0d got=%0d %b exp=%0d %b", b, blocks_done, digest_valid, b + 1, b == 1); end
    end
    checks++; if (digest_out !== d) begin errors++; $display("FAIL spur_digest got=%h exp=%h", digest_out, d); end
    digest_ready = 1'b1;
    @(negedge clk); digest_ready = 1'b0; #1;
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL spur_idle got=%b exp=1", cfg_ready); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_multi_block();
    test_zero_count();
    test_digest_backpressure();
    test_reset_mid_message();
    test_spurious_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
